// File: rtl/dpram_arb_pkg.sv
// Shared definitions for the dual-port RAM arbiter.
// Holds the default widths, the requester IDs and the read-tag type.
package dpram_arb_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // One entry of the read-return pipeline: valid bit plus owning requester
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dpram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a single preference pointer.
// After any grant the pointer moves to the other requester.
// Grants are forced low while rst is high.
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer next-state
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_q == REQ_B) ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
      if (gnt_o[0]) begin
        ptr_d = REQ_B;
      end else if (gnt_o[1]) begin
        ptr_d = REQ_A;
      end
    end
  end

  // Preference pointer; reset prefers requester A
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Two-requester scheduler for a dual-port RAM sharing one clock.
// Writes and reads are arbitrated independently, so one write and one
// read can be issued every cycle. Read data returns two cycles after
// grant with a valid pulse for the owner.
// Optional feature: define RAW_BYPASS_EN to forward the data of a write
// granted in the same cycle as a read of the same address.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_data_out,
  output logic          mem_rst
);

  logic [1:0] wreq;
  logic [1:0] rreq;
  logic [1:0] wgnt;
  logic [1:0] rgnt;

  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          rd_en_q,   rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  rd_tag_t       tag_p0_q,  tag_p0_d;
  rd_tag_t       tag_p1_q;

  assign wreq = {b_req &  b_we, a_req &  a_we};
  assign rreq = {b_req & ~b_we, a_req & ~a_we};

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (wreq),
    .gnt_o (wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (rreq),
    .gnt_o (rgnt)
  );

  // A requester sits in exactly one class per cycle, so OR-ing is safe
  assign a_gnt = wgnt[0] | rgnt[0];
  assign b_gnt = wgnt[1] | rgnt[1];

  // Select the granted command for each RAM port; addresses hold when idle
  always_comb begin
    wr_en_d   = |wgnt;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = |rgnt;
    rd_addr_d = rd_addr_q;
    tag_p0_d  = '{vld: |rgnt, id: rgnt[1] ? REQ_B : REQ_A};
    if (wgnt[1]) begin
      wr_addr_d = b_addr;
      wr_data_d = b_wdata;
    end else if (wgnt[0]) begin
      wr_addr_d = a_addr;
      wr_data_d = a_wdata;
    end
    if (rgnt[1]) begin
      rd_addr_d = b_addr;
    end else if (rgnt[0]) begin
      rd_addr_d = a_addr;
    end
  end

  // Stage p0: RAM command registers and first read-tag stage
  // Stage p1: read tag aligned with mem_data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tag_p0_q  <= '0;
      tag_p1_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tag_p0_q  <= tag_p0_d;
      tag_p1_q  <= tag_p0_q;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_data_in = wr_data_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_rst     = rst;

  assign a_rvalid = tag_p1_q.vld & (tag_p1_q.id == REQ_A);
  assign b_rvalid = tag_p1_q.vld & (tag_p1_q.id == REQ_B);

`ifdef RAW_BYPASS_EN
  logic          raw_hit;
  logic          raw_p0_q, raw_p1_q;
  logic [DW-1:0] byp_p0_q, byp_p1_q;

  assign raw_hit = (|wgnt) & (|rgnt) & (wr_addr_d == rd_addr_d);

  // Same-address hit flag, delayed to line up with the read return
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_p0_q <= 1'b0;
      raw_p1_q <= 1'b0;
    end else begin
      raw_p0_q <= raw_hit;
      raw_p1_q <= raw_p0_q;
    end
  end

  // Copy of the write data travelling alongside the hit flag
  always_ff @(posedge clk) begin
    byp_p0_q <= wr_data_d;
    byp_p1_q <= byp_p0_q;
  end

  assign rdata = raw_p1_q ? byp_p1_q : mem_data_out;
`else
  assign rdata = mem_data_out;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural 8x16 RAM that
// returns the old contents when read and written at the same address.
module tb_dpram_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

`ifdef RAW_BYPASS_EN
  localparam logic [15:0] RAW_EXP = 16'd80;
`else
  localparam logic [15:0] RAW_EXP = 16'd15;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_wr_en, mem_rd_en, mem_rst;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .rdata        (rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_data_out (mem_data_out),
    .mem_rst      (mem_rst)
  );

  // RAM model: registered read, read-before-write on same-edge collisions
  logic [DW-1:0] ram [8];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_data_in;
    if (mem_rst) mem_data_out <= '0;
    else if (mem_rd_en) mem_data_out <= ram[mem_rd_addr];
  end

  typedef struct {
    logic ar, awe; logic [2:0] aa; logic [15:0] awd;
    logic br, bwe; logic [2:0] ba; logic [15:0] bwd;
    logic eag, ebg;
    logic ewen; logic [2:0] ewa; logic [15:0] ewd;
    logic eren; logic [2:0] era;
    logic earv, ebrv; logic [15:0] erd;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(
    input logic ar, awe, input logic [2:0] aa, input logic [15:0] awd,
    input logic br, bwe, input logic [2:0] ba, input logic [15:0] bwd,
    input logic eag, ebg,
    input logic ewen, input logic [2:0] ewa, input logic [15:0] ewd,
    input logic eren, input logic [2:0] era,
    input logic earv, ebrv, input logic [15:0] erd);
    vec_t v;
    v.ar = ar; v.awe = awe; v.aa = aa; v.awd = awd;
    v.br = br; v.bwe = bwe; v.ba = ba; v.bwd = bwd;
    v.eag = eag; v.ebg = ebg;
    v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
    v.eren = eren; v.era = era;
    v.earv = earv; v.ebrv = ebrv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic ar, awe, input logic [2:0] aa, input logic [15:0] awd,
                       input logic br, bwe, input logic [2:0] ba, input logic [15:0] bwd);
    a_req = ar; a_we = awe; a_addr = aa; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = ba; b_wdata = bwd;
  endtask

  initial begin
    //            A: req we addr data   B: req we addr data  gnt A B  wr en addr data  rd en addr  rv A B data
    vecs[0]  = mk(1,1,1,50,   1,1,6,140,  1,0,  0,0,0,    0,0,  0,0,0);
    vecs[1]  = mk(1,1,1,50,   1,1,6,140,  0,1,  1,1,50,   0,0,  0,0,0);
    vecs[2]  = mk(1,1,1,50,   1,1,6,140,  1,0,  1,6,140,  0,0,  0,0,0);
    vecs[3]  = mk(1,1,1,50,   1,1,6,140,  0,1,  1,1,50,   0,0,  0,0,0);
    vecs[4]  = mk(0,0,0,0,    0,0,0,0,    0,0,  1,6,140,  0,0,  0,0,0);
    vecs[5]  = mk(1,1,5,200,  0,0,0,0,    1,0,  0,0,0,    0,0,  0,0,0);
    vecs[6]  = mk(1,0,5,0,    0,0,0,0,    1,0,  1,5,200,  0,0,  0,0,0);
    vecs[7]  = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    1,5,  0,0,0);
    vecs[8]  = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    0,0,  1,0,200);
    vecs[9]  = mk(1,1,1,70,   0,0,0,0,    1,0,  0,0,0,    0,0,  0,0,0);
    vecs[10] = mk(1,1,0,30,   1,0,1,0,    1,1,  1,1,70,   0,0,  0,0,0);
    vecs[11] = mk(0,0,0,0,    0,0,0,0,    0,0,  1,0,30,   1,1,  0,0,0);
    vecs[12] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    0,0,  0,1,70);
    vecs[13] = mk(0,0,0,0,    1,1,3,15,   0,1,  0,0,0,    0,0,  0,0,0);
    vecs[14] = mk(1,1,3,80,   1,0,3,0,    1,1,  1,3,15,   0,0,  0,0,0);
    vecs[15] = mk(0,0,0,0,    0,0,0,0,    0,0,  1,3,80,   1,3,  0,0,0);
    vecs[16] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    0,0,  0,1,RAW_EXP);
    vecs[17] = mk(1,0,3,0,    0,0,0,0,    1,0,  0,0,0,    0,0,  0,0,0);
    vecs[18] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    1,3,  0,0,0);
    vecs[19] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    0,0,  1,0,80);
    vecs[20] = mk(1,0,5,0,    1,0,1,0,    0,1,  0,0,0,    0,0,  0,0,0);
    vecs[21] = mk(1,0,5,0,    0,0,0,0,    1,0,  0,0,0,    1,1,  0,0,0);
    vecs[22] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    1,5,  0,1,70);
    vecs[23] = mk(0,0,0,0,    0,0,0,0,    0,0,  0,0,0,    0,0,  1,0,200);

    // Reset held two cycles with both requesters active
    rst = 1'b1;
    drive(1,1,0,16'h1234, 1,0,1,0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst a_gnt", -1, a_gnt, 0);
    chk("rst b_gnt", -1, b_gnt, 0);
    chk("rst mem_wr_en", -1, mem_wr_en, 0);
    chk("rst mem_rd_en", -1, mem_rd_en, 0);
    chk("rst mem_wr_addr", -1, mem_wr_addr, 0);
    chk("rst mem_rd_addr", -1, mem_rd_addr, 0);
    chk("rst mem_data_in", -1, mem_data_in, 0);
    chk("rst rvalid", -1, {a_rvalid, b_rvalid}, 0);
    chk("rst mem_rst", -1, mem_rst, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ar, vecs[i].awe, vecs[i].aa, vecs[i].awd,
            vecs[i].br, vecs[i].bwe, vecs[i].ba, vecs[i].bwd);
      @(negedge clk);
      chk("a_gnt", i, a_gnt, vecs[i].eag);
      chk("b_gnt", i, b_gnt, vecs[i].ebg);
      chk("mem_wr_en", i, mem_wr_en, vecs[i].ewen);
      if (vecs[i].ewen) begin
        chk("mem_wr_addr", i, mem_wr_addr, vecs[i].ewa);
        chk("mem_data_in", i, mem_data_in, vecs[i].ewd);
      end
      chk("mem_rd_en", i, mem_rd_en, vecs[i].eren);
      if (vecs[i].eren) chk("mem_rd_addr", i, mem_rd_addr, vecs[i].era);
      chk("a_rvalid", i, a_rvalid, vecs[i].earv);
      chk("b_rvalid", i, b_rvalid, vecs[i].ebrv);
      if (vecs[i].earv | vecs[i].ebrv) chk("rdata", i, rdata, vecs[i].erd);
      @(posedge clk);
      #1;
    end

    // Reset arriving while a B read is in flight
    drive(1,1,2,16'd5, 1,0,1,0);
    @(negedge clk);
    chk("flight a_gnt", 100, a_gnt, 1);
    chk("flight b_gnt", 100, b_gnt, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1,0,1,0, 1,0,5,0);
    @(negedge clk);
    chk("flight rst a_gnt", 101, a_gnt, 0);
    chk("flight rst b_gnt", 101, b_gnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("flight b_rvalid", 102, b_rvalid, 0);
    chk("flight a_rvalid", 102, a_rvalid, 0);
    chk("flight mem_rd_en", 102, mem_rd_en, 0);
    @(posedge clk);
    #1 drive(1,1,2,16'd9, 1,1,4,16'd11);
    @(negedge clk);
    chk("post-rst wr a_gnt", 103, a_gnt, 1);
    chk("post-rst wr b_gnt", 103, b_gnt, 0);
    @(posedge clk);
    #1 drive(1,0,1,0, 1,0,5,0);
    @(negedge clk);
    chk("post-rst rd a_gnt", 104, a_gnt, 1);
    chk("post-rst rd b_gnt", 104, b_gnt, 0);
    @(posedge clk);
    #1 drive(0,0,0,0, 0,0,0,0);
    @(posedge clk);
    @(negedge clk);
    chk("post-rst a_rvalid", 105, a_rvalid, 1);
    chk("post-rst rdata", 105, rdata, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Two-requester scheduler for the 8×16 dual-port RAM, with both RAM clocks tied to one system clock. Each cycle it grants at most one write (RAM write port) and at most one read (RAM read port). Contention on each port is resolved by an independent round-robin. Read data is returned to the owning requester with a valid pulse. It sits between two client engines and the RAM instance, and is the only driver of the RAM's control, address and data inputs.

## Interface
- AW, 3, address width (RAM depth 2^AW)
- DW, 16, data width
- clk  in  1  system clock; also drives the RAM's clk_wr and clk_rd
- rst  in  1  synchronous, active-high reset
- a_req  in  1  requester A operation pending
- a_we  in  1  1 = write, 0 = read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A operation accepted this cycle (combinational)
- a_rvalid  out  1  rdata belongs to A this cycle
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  (same as A, for requester B)
- rdata  out  DW  read data, shared by both requesters
- mem_wr_en  out  1  to RAM wr_en
- mem_wr_addr  out  AW  to RAM wr_addr
- mem_data_in  out  DW  to RAM data_in
- mem_rd_en  out  1  to RAM rd_en
- mem_rd_addr  out  AW  to RAM rd_addr
- mem_data_out  in  DW  from RAM data_out; valid one cycle after mem_rd_en is sampled
- mem_rst  out  1  to RAM rst; equals rst

## Operation
- Handshake:
  - x_req with x_we/x_addr/x_wdata is held stable until x_gnt.
  - The request counts as accepted in the cycle x_gnt=1.
  - The requester may present its next operation in the following cycle.
- Classes: a request is in the write class if x_we=1, otherwise in the read class. Each class has its own arbiter.
- Arbitration within a class:
  - One requester in the class: it is granted.
  - Both requesters in the class: the class pointer's preferred requester is granted; the other sees gnt=0 and holds.
- Pointer update: after any grant in a class, that class's pointer prefers the other requester.
- A write-class grant and a read-class grant may occur in the same cycle, e.g. A writes while B reads.
- Granted write: the registered mem_wr_en/mem_wr_addr/mem_data_in are loaded next edge.
- Granted read: the registered mem_rd_en/mem_rd_addr are loaded next edge. The owner ID enters a 2-stage valid pipeline.
- rdata = mem_data_out (combinational pass-through). x_rvalid marks its owner.
- Reset values:
  - all mem_* enables, mem_wr_addr, mem_rd_addr, mem_data_in: 0
  - a_rvalid, b_rvalid: 0
  - both pointers prefer A
  - valid pipeline cleared
- Reset mid-operation: in-flight reads are discarded. No rvalid fires after a cycle with rst=1. gnt is forced to 0 while rst=1.
- Only one read is issued per cycle, so a_rvalid and b_rvalid are never high together.

## Timing
- Cycle N: req sampled, gnt combinational in N.
- N+1: RAM command present on mem_*.
- N+2: for reads, mem_data_out is valid and x_rvalid=1.
- Read latency is 2 cycles from grant.
- Write data is visible to a read granted one or more cycles after the write's grant.
- Throughput: 1 write + 1 read per cycle sustained.
- Same-address write and read granted in the same cycle: handled per the RAW_BYPASS_EN setting (see Configuration).

## Configuration
- RAW_BYPASS_EN defined:
  - A read granted in the same cycle as a write to the same address returns that write's data.
  - Implementation: registered compare flag plus a registered copy of the write data, delayed to align with N+2; rdata is muxed.
- RAW_BYPASS_EN undefined: rdata is always mem_data_out, i.e. the RAM's own same-cycle read/write ordering.

## Structure
- Package dpram_arb_pkg: AW/DW defaults, requester ID constants (REQ_A=0, REQ_B=1), the valid-pipeline entry typedef (valid bit + owner ID).
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0] → gnt[1:0], internal pointer, sync reset). Instantiated twice, once for the write class and once for the read class.

## Test plan
- Reset: hold rst for 2 cycles with a_req=b_req=1 → a_gnt=b_gnt=0, all mem_* enables 0, no rvalid.
- Uncontested write then read:
  - A writes 200 to addr 5 → a_gnt in cycle N, mem_wr_en=1/mem_wr_addr=5 at N+1.
  - A then reads addr 5 → a_rvalid=1 with rdata=200 exactly 2 cycles after that read's grant.
- Write contention: A and B both request writes (A: addr 1 ← 50, B: addr 6 ← 140) held continuously → grants A, B, A, B in alternating cycles. Memory ends with the last values written.
- Mixed classes: A writes addr 0 ← 30 while B reads addr 1 (previously 70) → both granted in the same cycle, b_rvalid at N+2 with rdata=70.
- Same-cycle RAW: A writes addr 3 ← 80 while B reads addr 3 (previously 15):
  - with RAW_BYPASS_EN → rdata=80
  - without → rdata equals the RAM's behaviour, checked against the RAM model.
- Reset during read: B read granted at N, rst=1 at N+1 → b_rvalid stays 0 at N+2, and both pointers prefer A afterwards.
